// File: rtl/recog_scheduler.sv
// Frame capture / digit recognition scheduler: IDLE -> CAPTURE -> INFER -> RESULT.
// Optional inference watchdog with FAULT state is enabled by defining SCHED_TIMEOUT_EN.
module recog_scheduler (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold,
  input  logic               frame_done,
  input  logic               cap_wren,
  input  logic [9:0]         cap_addr,
  input  logic signed [31:0] cap_data,
  input  logic               retrieve_done,
  input  logic [9:0]         nn_addr,
  output logic               nn_start,
  input  logic               nn_done,
  input  logic [3:0]         nn_digit,
  output logic [9:0]         ram_addr,
  output logic [31:0]        ram_wdata,
  output logic               ram_wren,
  output logic [3:0]         digit_out,
  output logic               digit_valid,
  output logic               busy,
  output logic [2:0]         state_dbg,
  output logic [7:0]         drop_cnt,
  output logic               timeout_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIG_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    INFER   = 3'd2,
    RESULT  = 3'd3
`ifdef SCHED_TIMEOUT_EN
    , FAULT = 3'd4
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   digit_out_q;
  logic               digit_valid_q;
  logic               nn_start_q;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic               drop_hit_c;
  logic               timeout_hit_c;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WDOG_W      = 16;
  localparam int unsigned TIMEOUT_CYC = 50000;

  logic [WDOG_W-1:0]  wdog_q;
  logic               timeout_err_q;

  assign timeout_hit_c = (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit_c = 1'b0;
`endif

  // Next-state logic; nn_done beats a coincident watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_done && hold) state_d = CAPTURE;
      CAPTURE: if (retrieve_done)      state_d = INFER;
      INFER: begin
        if (nn_done)            state_d = RESULT;
`ifdef SCHED_TIMEOUT_EN
        else if (timeout_hit_c) state_d = FAULT;
`endif
      end
      RESULT:  state_d = IDLE;
`ifdef SCHED_TIMEOUT_EN
      FAULT:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // A frame arriving while busy is dropped, unless it coincides with capture completion
  always_comb begin
    drop_hit_c = 1'b0;
    if (frame_done) begin
      case (state_q)
        CAPTURE: drop_hit_c = !retrieve_done;
        INFER:   drop_hit_c = 1'b1;
        RESULT:  drop_hit_c = 1'b1;
        default: drop_hit_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      digit_out_q   <= '0;
      digit_valid_q <= 1'b0;
      nn_start_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      nn_start_q    <= (state_d == INFER) && (state_q != INFER);
      digit_valid_q <= (state_q == INFER) && (state_d == RESULT);
      if ((state_q == INFER) && (state_d == RESULT)) digit_out_q <= nn_digit;
      if (drop_hit_c && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Watchdog counts INFER cycles and is cleared whenever outside INFER
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == INFER) wdog_q <= wdog_q + WDOG_W'(1);
      else                  wdog_q <= '0;
      if (state_d == FAULT) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Capture owns the RAM port only in CAPTURE; otherwise the network reads it
  always_comb begin
    ram_addr  = nn_addr;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (state_q == CAPTURE) begin
      ram_addr  = cap_addr;
      ram_wdata = cap_data;
      ram_wren  = cap_wren && reset_n;
    end
  end

  assign nn_start    = nn_start_q;
  assign digit_out   = digit_out_q;
  assign digit_valid = digit_valid_q;
  assign drop_cnt    = drop_cnt_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: doc/recog_scheduler.md
RECOG_SCHEDULER -- requirements
Module: recog_scheduler

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock); reset_n in 1 (synchronous, active-low reset).
REQ-002 SHALL have ports: hold in 1 (active low; 0 blocks new capture starts); frame_done in 1 (VGA end-of-frame pulse).
REQ-003 SHALL have capture-side ports: cap_wren in 1; cap_addr in 10; cap_data in 32 (signed); retrieve_done in 1 (capture complete pulse).
REQ-004 SHALL have network-side ports: nn_addr in 10 (read address); nn_start out 1; nn_done in 1; nn_digit in 4.
REQ-005 SHALL have image RAM ports: ram_addr out 10; ram_wdata out 32; ram_wren out 1.
REQ-006 SHALL have status ports: digit_out out 4; digit_valid out 1; busy out 1; state_dbg out 3; drop_cnt out 8; timeout_err out 1.

Function
REQ-007 SHALL implement states IDLE, CAPTURE, INFER, RESULT and, when configured, FAULT.
REQ-008 In IDLE, SHALL move to CAPTURE on the cycle after frame_done=1 with hold=1; otherwise SHALL stay in IDLE.
REQ-009 In CAPTURE, SHALL drive ram_addr=cap_addr, ram_wdata=cap_data and ram_wren=cap_wren combinationally, with no added latency.
REQ-010 In CAPTURE, SHALL move to INFER on retrieve_done=1; if frame_done=1 occurs in the same cycle, retrieve_done wins and the frame is not counted as dropped.
REQ-011 On entry to INFER, SHALL assert nn_start for exactly one cycle.
REQ-012 In INFER, RESULT and IDLE, SHALL drive ram_wren=0 and ram_addr=nn_addr; cap_wren in these states is ignored and does not reach RAM.
REQ-013 In INFER, SHALL move to RESULT on nn_done=1; nn_done in any other state is ignored.
REQ-014 In RESULT, SHALL register digit_out<=nn_digit, pulse digit_valid for one cycle, and return to IDLE the next cycle.
REQ-015 digit_out SHALL hold its value until the next RESULT.
REQ-016 SHALL increment drop_cnt by one for each frame_done=1 seen in CAPTURE (except per REQ-010), INFER or RESULT; drop_cnt SHALL saturate at 255.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 state_dbg SHALL encode IDLE=0, CAPTURE=1, INFER=2, RESULT=3, FAULT=4.
REQ-019 hold going to 0 mid-run SHALL NOT abort the run; it only blocks the next start from IDLE.
REQ-020 ram_wdata SHALL be 0 outside CAPTURE.

Reset
REQ-021 While reset_n=0 at a clk edge: state=IDLE; digit_out=0; digit_valid=0; nn_start=0; drop_cnt=0; timeout_err=0; watchdog=0.
REQ-022 Reset mid-CAPTURE or mid-INFER SHALL abandon the run with no digit_valid and no nn_start.
REQ-023 ram_wren SHALL be 0 during reset regardless of cap_wren.

Configuration
REQ-024 Macro SCHED_TIMEOUT_EN: when defined, a 16-bit watchdog SHALL clear on INFER entry and count each INFER cycle.
REQ-025 With SCHED_TIMEOUT_EN, reaching 50000 INFER cycles without nn_done SHALL go to FAULT, set timeout_err=1 (sticky until reset), and return to IDLE the next cycle.
REQ-026 With SCHED_TIMEOUT_EN, nn_done on the same cycle as the timeout SHALL win and go to RESULT.
REQ-027 Without SCHED_TIMEOUT_EN, there SHALL be no watchdog or FAULT state, timeout_err SHALL be tied to 0, and INFER SHALL wait indefinitely.

Verification
REQ-028 Bench SHALL cover the nominal run: reset, then hold=1, frame_done pulse, 1024 cap_wren writes addr 0..1023 with data 0x01000000, retrieve_done, nn_done with nn_digit=7 -> 1024 RAM writes, one nn_start pulse, digit_out=7, one digit_valid pulse, busy back to 0.
REQ-029 Bench SHALL cover hold blocking: hold=0 with frame_done pulse -> state_dbg stays 0 and ram_wren stays 0.
REQ-030 Bench SHALL cover write blocking: cap_wren=1 during INFER with nn_addr=5 -> ram_wren=0 and ram_addr=5.
REQ-031 Bench SHALL cover drop counting: 3 frame_done pulses during INFER -> drop_cnt=3; 300 such pulses -> drop_cnt=255.
REQ-032 Bench SHALL cover reset mid-run: reset_n=0 at write 500 of CAPTURE -> state_dbg=0, no digit_valid; a following full run completes normally.
REQ-033 Bench SHALL cover the watchdog: with SCHED_TIMEOUT_EN and no nn_done -> FAULT at INFER cycle 50000, timeout_err=1, then IDLE; without the macro -> still INFER after 60000 cycles.
